// File: rtl/fc_relu_packer_if.sv
// Bus bundle for fc_relu_packer: the neuron-sum stream in, the frame handshake,
// the sparse frame outputs and the packed-element read port.
// Optional macro FC_RELU_PACKER_INC_IDX_EN adds the running nonzero-index lookup port.
interface fc_relu_packer_if #(
  parameter int N_NEURONS = 128,
  parameter int AW        = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_data;
  logic [15:0]          in_bias;
  logic                 in_last;
  logic                 frame_done;
  logic                 frame_ack;
  logic [N_NEURONS-1:0] idx_bitmap;
  logic [AW:0]          nz_count;
  logic [AW:0]          beat_count;
  logic                 sat_flag;
  logic [AW-1:0]        rd_addr;
  logic [8:0]           rd_data;
`ifdef FC_RELU_PACKER_INC_IDX_EN
  logic [AW-1:0]        inc_rd_addr;
  logic [AW:0]          inc_rd_data;
`endif

  // Upstream stage and consumer side.
  modport master (
    output in_valid, in_data, in_bias, in_last, frame_ack, rd_addr,
`ifdef FC_RELU_PACKER_INC_IDX_EN
    output inc_rd_addr,
    input  inc_rd_data,
`endif
    input  in_ready, frame_done, idx_bitmap, nz_count, beat_count, sat_flag, rd_data
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_bias, in_last, frame_ack, rd_addr,
`ifdef FC_RELU_PACKER_INC_IDX_EN
    input  inc_rd_addr,
    output inc_rd_data,
`endif
    output in_ready, frame_done, idx_bitmap, nz_count, beat_count, sat_flag, rd_data
  );
endinterface

// File: rtl/fc_relu_packer.sv
// fc_relu_packer: bias add, ReLU and requantize each neuron sum to 9-bit signed,
// then pack the frame into a nonzero bitmap plus a dense list of nonzero values.
// Optional macro FC_RELU_PACKER_INC_IDX_EN adds inc_rd_addr/inc_rd_data, which
// return the count of set bitmap bits at positions 0..inc_rd_addr.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting neuron beats, building bitmap and packed store
// DONE    | frame complete and frozen, waiting for frame_ack
module fc_relu_packer #(
  parameter int N_NEURONS = 128,
  parameter int SHIFT     = 4,
  parameter int AW        = 7
) (
  input logic           clk,
  input logic           reset,
  fc_relu_packer_if.slave bus
);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t state, state_next;
  logic   ready, done;
  logic   accept, final_beat;

  logic [16:0] sum;
  logic [16:0] shifted;
  logic        positive;
  logic        clip;
  logic [8:0]  q;

  logic [N_NEURONS-1:0] bitmap;
  logic [AW:0]          nz;
  logic [AW:0]          beats;
  logic                 sat;
  logic [8:0]           rd_data_r;
  logic [8:0]           mem [N_NEURONS];

  // Requantize: 17-bit sum never wraps; non-positive sums become 0, large ones clip to 255.
  always_comb begin
    sum      = {bus.in_data[15], bus.in_data} + {bus.in_bias[15], bus.in_bias};
    positive = !sum[16] && (sum != '0);
    shifted  = sum >> SHIFT;
    clip     = positive && (shifted > 17'd255);
    q        = '0;
    if (positive) begin
      q = clip ? 9'd255 : {1'b0, shifted[7:0]};
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    final_beat = bus.in_last || (beats == (AW+1)'(N_NEURONS-1));
    case (state)
      COLLECT: begin
        ready  = 1'b1;
        accept = bus.in_valid;
        if (accept && final_beat) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.frame_ack) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // Frame bookkeeping: bitmap, counters and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap <= '0;
      nz     <= '0;
      beats  <= '0;
      sat    <= 1'b0;
    end else if (state == DONE && bus.frame_ack) begin
      bitmap <= '0;
      nz     <= '0;
      beats  <= '0;
      sat    <= 1'b0;
    end else if (accept) begin
      beats <= beats + 1'b1;
      if (q != '0) begin
        bitmap[beats[AW-1:0]] <= 1'b1;
        nz                    <= nz + 1'b1;
      end
      if (clip) sat <= 1'b1;
    end
  end

  // Packed element store; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && accept && q != '0) mem[nz[AW-1:0]] <= q;
  end

  // Registered read port; a same-cycle write to the same address returns old data.
  always_ff @(posedge clk) begin
    if (reset) rd_data_r <= '0;
    else       rd_data_r <= mem[bus.rd_addr];
  end

`ifdef FC_RELU_PACKER_INC_IDX_EN
  logic [AW:0] inc_count;
  logic [AW:0] inc_data_r;

  // Prefix popcount of the bitmap up to and including inc_rd_addr.
  always_comb begin
    inc_count = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (AW'(i) <= bus.inc_rd_addr) inc_count = inc_count + (AW+1)'(bitmap[i]);
    end
  end

  // Register the prefix count for a one-cycle lookup latency.
  always_ff @(posedge clk) begin
    if (reset) inc_data_r <= '0;
    else       inc_data_r <= inc_count;
  end

  assign bus.inc_rd_data = inc_data_r;
`endif

  assign bus.in_ready   = ready;
  assign bus.frame_done = done;
  assign bus.idx_bitmap = bitmap;
  assign bus.nz_count   = nz;
  assign bus.beat_count = beats;
  assign bus.sat_flag   = sat;
  assign bus.rd_data    = rd_data_r;

endmodule

// File: tb/tb_fc_relu_packer.sv
// Self-checking bench for fc_relu_packer: directed and random frames compared
// against an arithmetic reference model of the activation and packing rules.
module tb_fc_relu_packer;
  localparam int N  = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset;

  fc_relu_packer_if #(.N_NEURONS(N), .AW(AW)) bus ();

  fc_relu_packer #(.N_NEURONS(N), .SHIFT(4), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0]  din [N];
  logic [15:0]  bin [N];
  int           mem_m [N];
  bit           mem_known [N];
  logic [127:0] exp_bitmap;
  int           exp_nz;
  int           exp_beats;
  bit           exp_sat;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_q(input logic [15:0] d, input logic [15:0] b, output bit s);
    int v;
    v = int'($signed(d)) + int'($signed(b));
    s = 1'b0;
    if (v <= 0) return 0;
    v = v / 16;
    if (v > 255) begin
      s = 1'b1;
      return 255;
    end
    return v;
  endfunction

  task automatic model_clear();
    exp_bitmap = '0;
    exp_nz     = 0;
    exp_beats  = 0;
    exp_sat    = 1'b0;
  endtask

  task automatic model_beat(input int p, input logic [15:0] d, input logic [15:0] b);
    int q;
    bit s;
    q = ref_q(d, b, s);
    if (s) exp_sat = 1'b1;
    if (q != 0) begin
      exp_bitmap[p]     = 1'b1;
      mem_m[exp_nz]     = q;
      mem_known[exp_nz] = 1'b1;
      exp_nz++;
    end
    exp_beats++;
  endtask

  task automatic run_frame(input int len, input int last_at, input bit gaps);
    int old0;
    bit known0;
    old0   = mem_m[0];
    known0 = mem_known[0];
    model_clear();
    bus.rd_addr = '0;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = din[i];
      bus.in_bias  = bin[i];
      bus.in_last  = (i == last_at);
      if (i == len - 1) check_val("done_before_final", bus.frame_done, 1'b0);
      @(posedge clk); #1;
      model_beat(i, din[i], bin[i]);
      if (i == 0 && known0) check_val("rd_old_on_write", bus.rd_data, old0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_val("done_after_final", bus.frame_done, 1'b1);
    check_val("ready_in_done", bus.in_ready, 1'b0);
  endtask

  task automatic check_frame();
    check_val("bitmap", bus.idx_bitmap, exp_bitmap);
    check_val("nz_count", bus.nz_count, exp_nz);
    check_val("beat_count", bus.beat_count, exp_beats);
    check_val("sat_flag", bus.sat_flag, exp_sat);
    for (int k = 0; k < exp_nz; k++) begin
      bus.rd_addr = AW'(k);
      @(posedge clk); #1;
      check_val("rd_data", bus.rd_data, mem_m[k]);
    end
`ifdef FC_RELU_PACKER_INC_IDX_EN
    for (int t = 0; t < 6; t++) begin
      int a;
      int c;
      case (t)
        0: a = 1;
        1: a = 2;
        2: a = 3;
        3: a = 127;
        default: a = $urandom_range(127);
      endcase
      c = 0;
      for (int j = 0; j <= a; j++) c += int'(exp_bitmap[j]);
      bus.inc_rd_addr = AW'(a);
      @(posedge clk); #1;
      check_val("inc_rd_data", bus.inc_rd_data, c);
    end
`endif
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1000;
    bus.in_bias  = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_val("done_ignore_beats", bus.beat_count, exp_beats);
    check_val("done_ignore_nz", bus.nz_count, exp_nz);
    check_val("done_held", bus.frame_done, 1'b1);
  endtask

  task automatic ack_frame();
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    check_val("ack_bitmap", bus.idx_bitmap, '0);
    check_val("ack_nz", bus.nz_count, 0);
    check_val("ack_beats", bus.beat_count, 0);
    check_val("ack_sat", bus.sat_flag, 1'b0);
    check_val("ack_ready", bus.in_ready, 1'b1);
    check_val("ack_done", bus.frame_done, 1'b0);
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(2))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(600)) - 16'd200;
      default: return 16'd0;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int last_at;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bias   = '0;
    bus.in_last   = 1'b0;
    bus.frame_ack = 1'b0;
    bus.rd_addr   = '0;
`ifdef FC_RELU_PACKER_INC_IDX_EN
    bus.inc_rd_addr = '0;
`endif
    for (int i = 0; i < N; i++) mem_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_ready", bus.in_ready, 1'b1);
    check_val("rst_done", bus.frame_done, 1'b0);
    check_val("rst_bitmap", bus.idx_bitmap, '0);
    check_val("rst_nz", bus.nz_count, 0);
    check_val("rst_beats", bus.beat_count, 0);
    check_val("rst_sat", bus.sat_flag, 1'b0);
    check_val("rst_rd_data", bus.rd_data, 0);
`ifdef FC_RELU_PACKER_INC_IDX_EN
    check_val("rst_inc", bus.inc_rd_data, 0);
`endif

    // Full frame of small positive values.
    for (int i = 0; i < N; i++) begin din[i] = 16'd16; bin[i] = 16'd0; end
    run_frame(N, -1, 1'b0);
    check_val("full_bitmap_ones", bus.idx_bitmap, {128{1'b1}});
    check_frame();
    ack_frame();

    // Mixed signs, sub-threshold value and saturation.
    for (int i = 0; i < N; i++) begin din[i] = 16'd0; bin[i] = 16'd0; end
    din[0] = -16'sd50; din[1] = 16'd15; din[2] = 16'd32; din[3] = 16'd5000;
    run_frame(N, -1, 1'b0);
    check_val("mixed_bitmap", bus.idx_bitmap, 128'hC);
    check_frame();
    ack_frame();

    // Bias add and 17-bit overflow corners, ended early.
    din[0] = -16'sd10;     bin[0] = 16'd42;
    din[1] = 16'h7FFF;     bin[1] = 16'h7FFF;
    din[2] = 16'h8000;     bin[2] = 16'h8000;
    run_frame(3, 2, 1'b0);
    check_frame();
    ack_frame();

    // Early in_last at p=5.
    for (int i = 0; i < 6; i++) begin din[i] = 16'd64; bin[i] = 16'd0; end
    run_frame(6, 5, 1'b0);
    check_val("early_bitmap", bus.idx_bitmap, 128'h3F);
    check_frame();
    ack_frame();

    // frame_ack while collecting has no effect.
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
    check_val("ack_in_collect_ready", bus.in_ready, 1'b1);
    check_val("ack_in_collect_done", bus.frame_done, 1'b0);

    // Random frames with random lengths, early ends and input gaps.
    for (int f = 0; f < 6; f++) begin
      len = (f == 0) ? N : $urandom_range(1, N);
      last_at = (len < N) ? len - 1 : (($urandom_range(1) == 0) ? -1 : N - 1);
      for (int i = 0; i < N; i++) begin din[i] = rand_val(); bin[i] = rand_val(); end
      run_frame(len, last_at, 1'b1);
      check_frame();
      ack_frame();
    end

    // Reset mid-frame after 60 beats of 48.
    model_clear();
    for (int i = 0; i < 60; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd48;
      bus.in_bias  = 16'd0;
      bus.in_last  = 1'b0;
      @(posedge clk); #1;
      model_beat(i, 16'd48, 16'd0);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("midrst_ready", bus.in_ready, 1'b1);
    check_val("midrst_done", bus.frame_done, 1'b0);
    check_val("midrst_nz", bus.nz_count, 0);
    check_val("midrst_beats", bus.beat_count, 0);
    check_val("midrst_bitmap", bus.idx_bitmap, '0);
    for (int i = 0; i < N; i++) begin din[i] = rand_val(); bin[i] = rand_val(); end
    run_frame(N, -1, 1'b1);
    check_frame();
    ack_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_relu_packer.md
Name: fc_relu_packer

Overview:
- Downstream neighbour of the FC sparse dot-product stage. Consumes the signed 16-bit neuron sums it produces, one neuron per beat.
- Per neuron: adds a bias, applies ReLU, then requantizes to the signed 9-bit activation format.
- Writes each layer output into the sparse form used by the next FC layer: a 128-bit nonzero index bitmap plus a packed list of the nonzero activations.
- Holds the finished frame until the consumer acknowledges it.

Parameters:
- N_NEURONS, 128, neurons per frame and bitmap width.
- SHIFT, 4, arithmetic right shift applied after bias add and ReLU.
- AW, 7, address width of the packed element store, clog2(N_NEURONS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  neuron sum beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  16  signed neuron sum.
- in_bias  in  16  signed bias for this neuron.
- in_last  in  1  final neuron of frame (early end allowed).
- frame_done  out  1  frame complete, outputs stable.
- frame_ack  in  1  consumer releases frame.
- idx_bitmap  out  N_NEURONS  bit k = 1 when neuron k is nonzero.
- nz_count  out  AW+1  number of nonzero activations stored.
- beat_count  out  AW+1  neurons received in this frame.
- sat_flag  out  1  sticky per frame; set when any neuron saturated.
- rd_addr  in  AW  packed element read address.
- rd_data  out  9  signed packed element at rd_addr, registered.

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - state = COLLECT, in_ready = 1, frame_done = 0.
  - idx_bitmap = 0, nz_count = 0, beat_count = 0, sat_flag = 0, rd_data = 0.
  - The element store is not cleared.
  - Reset mid-frame discards the partial frame; the next cycle behaves as a fresh frame.
- FSM states:
  - COLLECT: in_ready = 1. A beat is accepted when in_valid && in_ready.
  - DONE: in_ready = 0, frame_done = 1. in_valid is ignored.
- Per accepted beat, at position p = beat_count:
  - sum = in_data + in_bias, computed 17-bit signed, so it never wraps.
  - If sum <= 0, then q = 0.
  - Otherwise q = sum >>> SHIFT, saturated to 255. When saturation clips, sat_flag is set.
  - If q != 0: idx_bitmap[p] = 1, mem[nz_count] = q, nz_count += 1.
  - If q == 0: nothing is stored and the bitmap bit stays 0.
  - beat_count += 1 in both cases.
- Transitions:
  - COLLECT -> DONE on the accepted beat with in_last = 1, or on the accepted beat at p = N_NEURONS-1, whichever comes first.
  - frame_done rises the cycle after that final beat.
  - On an early in_last, bitmap bits above p stay 0.
  - DONE -> COLLECT on frame_ack. In the same edge, bitmap, nz_count, beat_count and sat_flag clear, and in_ready = 1 the next cycle.
  - frame_ack while in COLLECT is ignored.
- Outputs: idx_bitmap, nz_count, beat_count and sat_flag are registered. Only their DONE-state values are meaningful to the consumer.
- Read port:
  - rd_data = mem[rd_addr] one cycle after rd_addr is presented, valid in either state.
  - Addresses >= nz_count return stale, unspecified data.
- Simultaneous events:
  - reset overrides everything.
  - A write to mem and a read of the same address in the same cycle returns the old data.
- Throughput: one neuron per cycle, no bubbles within a frame. One dead cycle minimum between frames (the ack cycle).

Optional Feature:
- Macro: FC_RELU_PACKER_INC_IDX_EN.
- When defined:
  - Adds inputs inc_rd_addr (AW) and output inc_rd_data (AW+1).
  - inc_rd_data, registered with 1-cycle latency, equals the count of set idx_bitmap bits in positions 0..inc_rd_addr inclusive. This is the running nonzero index the downstream sparse multiplier uses to locate packed elements.
  - Valid in DONE. Reset value is 0.
- When not defined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset; 128 beats of in_data=16, in_bias=0 -> frame_done rises the cycle after beat 128; idx_bitmap all ones; nz_count=128; mem[0..127]=1; sat_flag=0.
- Beats [-50, 15, 32, 5000] then 124 zeros -> idx_bitmap=0x...0C (bits 2,3); nz_count=2; rd_addr 0/1 -> 2/255; sat_flag=1.
- Bias and overflow: (in_data=-10, bias=42) -> 2; (32767, 32767) -> 255 with no wrap; (-32768, -32768) -> 0.
- in_last on beat 6 (p=5), all inputs 64 -> beat_count=6; bitmap=0x3F; nz_count=6; bits 6..127 = 0; in_ready=0 and in_valid ignored until frame_ack; after ack a new frame starts with bitmap=0.
- Reset asserted after 60 beats of value 48 -> next cycle in_ready=1, frame_done=0, nz_count=0, beat_count=0, bitmap=0; a following 128-beat frame completes correctly.
- With FC_RELU_PACKER_INC_IDX_EN, bitmap from the second scenario -> inc_rd_addr 1/2/3/127 -> inc_rd_data 0/1/2/2.
